// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
// Segment codes are active-high {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Pad-level (active-low) idle values.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'hF;

  typedef enum logic [1:0] {
    PH_GUARD,
    PH_ON,
    PH_OFF
  } slot_phase_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment decoder.
// Non-decimal nibbles render as a dash.
module bcd_to_7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_DASH;
    case (bcd)
      4'd0:    segs = SEG_0;
      4'd1:    segs = SEG_1;
      4'd2:    segs = SEG_2;
      4'd3:    segs = SEG_3;
      4'd4:    segs = SEG_4;
      4'd5:    segs = SEG_5;
      4'd6:    segs = SEG_6;
      4'd7:    segs = SEG_7;
      4'd8:    segs = SEG_8;
      4'd9:    segs = SEG_9;
      default: segs = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_sched.sv
// Four-digit common-anode scan scheduler: per-frame snapshot, guard blanking,
// PWM brightness window and leading-zero suppression, registered outputs.
module seg_scan_sched
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYC  = 1024,
  parameter int GUARD_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_bcd,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  input  logic [2:0]  brightness,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int CW   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int STEP = (SLOT_CYC - GUARD_CYC) / 8;

  logic [CW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic [15:0]   digits_q;
  logic [3:0]    en_q;
  logic          lz_q;
  logic [2:0]    bright_q;

  logic          slot_last;
  logic          frame_head;
  logic [3:0]    cur_nib;
  logic [6:0]    cur_code;
  logic [3:0]    suppress;
  logic [31:0]   slot_ext;
  logic [31:0]   on_end;
  slot_phase_t   phase;
  logic          lit;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  assign slot_last  = (slot_cnt == CW'(SLOT_CYC - 1));
  assign frame_head = (slot_cnt == '0) && (idx == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= 2'd0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // Frame contents are frozen at the start of digit 0's slot so a frame never mixes old and new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      en_q     <= '0;
      lz_q     <= 1'b0;
      bright_q <= '0;
    end else begin
      if (frame_head) begin
        digits_q <= digits_bcd;
        en_q     <= digit_en;
        lz_q     <= blank_lz;
      end
      if (slot_cnt == '0) begin
        bright_q <= brightness;
      end
    end
  end

  always_comb begin
    cur_nib = digits_q[3:0];
    case (idx)
      2'd0: cur_nib = digits_q[3:0];
      2'd1: cur_nib = digits_q[7:4];
      2'd2: cur_nib = digits_q[11:8];
      2'd3: cur_nib = digits_q[15:12];
      default: cur_nib = digits_q[3:0];
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd  (cur_nib),
    .segs (cur_code)
  );

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    suppress    = 4'b0000;
    suppress[3] = lz_q && (digits_q[15:12] == 4'd0);
    suppress[2] = suppress[3] && (digits_q[11:8] == 4'd0);
    suppress[1] = suppress[2] && (digits_q[7:4] == 4'd0);
  end

  always_comb begin
    slot_ext = 32'(slot_cnt);
    on_end   = 32'(GUARD_CYC) + (32'(bright_q) + 32'd1) * 32'(STEP);
    phase    = PH_OFF;
    if (slot_ext < 32'(GUARD_CYC)) begin
      phase = PH_GUARD;
    end else if (slot_ext < on_end) begin
      phase = PH_ON;
    end
    lit      = (phase == PH_ON) && en_q[idx] && !suppress[idx];
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    if (lit) begin
      an_next[idx] = 1'b0;
      seg_next     = ~cur_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      an          <= an_next;
      seg         <= seg_next;
      frame_start <= frame_head;
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed self-checking bench for seg_scan_sched with SLOT_CYC=16, GUARD_CYC=8.
// Cycle c means the value visible after the c-th rising edge following reset release.
module tb_seg_scan_sched;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_bcd;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [2:0]  brightness;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  seg_scan_sched #(.SLOT_CYC(16), .GUARD_CYC(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_bcd  (digits_bcd),
    .digit_en    (digit_en),
    .blank_lz    (blank_lz),
    .brightness  (brightness),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pad values for cycle c; segs holds four active-low codes, digit d at [d*7 +: 7].
  function automatic logic [3:0] exp_an(int c, int onlen, logic [3:0] lit);
    int slot = (c - 1) % 16;
    int d    = ((c - 1) / 16) % 4;
    logic [3:0] r = 4'hF;
    if (slot >= 8 && slot < 8 + onlen && lit[d]) r[d] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(int c, int onlen, logic [3:0] lit, logic [27:0] segs);
    int slot = (c - 1) % 16;
    int d    = ((c - 1) / 16) % 4;
    if (slot >= 8 && slot < 8 + onlen && lit[d]) return segs[d*7 +: 7];
    return 7'h7F;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    digits_bcd = 16'h1234; digit_en = 4'hF; blank_lz = 1'b0; brightness = 3'd7;
    rst_n = 1'b0;
    #23;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || frame_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: an=%h seg=%h fs=%b, want an=F seg=7F fs=0", an, seg, frame_start);
    end
    do_reset();
    for (int c = 1; c <= 43; c++) next_cycle();
    checks++;
    if (an !== 4'hB || seg !== 7'h24) begin
      errors++;
      $display("[TB] FAIL digit2_lit: an=%h seg=%h, want an=B seg=24", an, seg);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || frame_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: an=%h seg=%h fs=%b, want an=F seg=7F fs=0", an, seg, frame_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      if (c == 1) begin
        checks++;
        if (frame_start !== 1'b1) begin
          errors++;
          $display("[TB] FAIL restart_fs: fs=%b, want 1", frame_start);
        end
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (an !== ((c == 9) ? 4'hE : 4'hF)) begin
          errors++;
          $display("[TB] FAIL restart_an c=%0d: an=%h, want %h", c, an, (c == 9) ? 4'hE : 4'hF);
        end
      end
    end
  endtask

  task automatic test_scan();
    logic [27:0] segs = {7'h79, 7'h24, 7'h30, 7'h19};
    digits_bcd = 16'h1234; digit_en = 4'hF; blank_lz = 1'b0; brightness = 3'd7;
    do_reset();
    for (int c = 1; c <= 130; c++) begin
      next_cycle();
      checks++;
      if (an !== exp_an(c, 8, 4'hF) || seg !== exp_seg(c, 8, 4'hF, segs)) begin
        errors++;
        $display("[TB] FAIL scan c=%0d: an=%h seg=%h, want an=%h seg=%h", c, an, seg,
                 exp_an(c, 8, 4'hF), exp_seg(c, 8, 4'hF, segs));
      end
      checks++;
      if (frame_start !== (c % 64 == 1)) begin
        errors++;
        $display("[TB] FAIL frame_start c=%0d: fs=%b, want %b", c, frame_start, c % 64 == 1);
      end
    end
  endtask

  task automatic test_lz();
    logic [27:0] segs = {7'h40, 7'h40, 7'h78, 7'h40};
    digits_bcd = 16'h0070; digit_en = 4'hF; blank_lz = 1'b1; brightness = 3'd7;
    do_reset();
    for (int c = 1; c <= 64; c++) begin
      next_cycle();
      checks++;
      if (an !== exp_an(c, 8, 4'b0011) || seg !== exp_seg(c, 8, 4'b0011, segs)) begin
        errors++;
        $display("[TB] FAIL leading_zero c=%0d: an=%h seg=%h, want an=%h seg=%h", c, an, seg,
                 exp_an(c, 8, 4'b0011), exp_seg(c, 8, 4'b0011, segs));
      end
    end
  endtask

  task automatic test_brightness();
    int lows [4];
    for (int b = 0; b < 2; b++) begin
      digits_bcd = 16'h5678; digit_en = 4'hF; blank_lz = 1'b0;
      brightness = (b == 0) ? 3'd0 : 3'd3;
      do_reset();
      for (int d = 0; d < 4; d++) lows[d] = 0;
      for (int c = 1; c <= 64; c++) begin
        next_cycle();
        for (int d = 0; d < 4; d++) if (an[d] == 1'b0) lows[d]++;
      end
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (lows[d] != ((b == 0) ? 1 : 4)) begin
          errors++;
          $display("[TB] FAIL brightness%0d digit%0d: low cycles=%0d, want %0d",
                   (b == 0) ? 0 : 3, d, lows[d], (b == 0) ? 1 : 4);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [27:0] ones  = {4{7'h79}};
    logic [27:0] nines = {4{7'h10}};
    digits_bcd = 16'h1111; digit_en = 4'hF; blank_lz = 1'b0; brightness = 3'd7;
    do_reset();
    for (int c = 1; c <= 128; c++) begin
      next_cycle();
      if (c == 36) digits_bcd = 16'h9999;
      checks++;
      if (seg !== exp_seg(c, 8, 4'hF, (c <= 64) ? ones : nines)) begin
        errors++;
        $display("[TB] FAIL snapshot c=%0d: seg=%h, want %h", c, seg,
                 exp_seg(c, 8, 4'hF, (c <= 64) ? ones : nines));
      end
    end
  endtask

  task automatic test_enable();
    logic [27:0] segs = {7'h3F, 7'h40, 7'h40, 7'h40};
    logic [3:0]  lit;
    digits_bcd = 16'hA000; digit_en = 4'b0111; blank_lz = 1'b0; brightness = 3'd7;
    do_reset();
    for (int c = 1; c <= 192; c++) begin
      next_cycle();
      if (c == 70) digit_en = 4'hF;
      lit = (c <= 128) ? 4'b0111 : 4'hF;
      checks++;
      if (an !== exp_an(c, 8, lit) || seg !== exp_seg(c, 8, lit, segs)) begin
        errors++;
        $display("[TB] FAIL enable c=%0d: an=%h seg=%h, want an=%h seg=%h", c, an, seg,
                 exp_an(c, 8, lit), exp_seg(c, 8, lit, segs));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    digits_bcd = '0; digit_en = '0; blank_lz = 1'b0; brightness = '0;
    test_reset();
    test_scan();
    test_lz();
    test_brightness();
    test_snapshot();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
